regsfile_mp: RTL and testbench

Parametrised multi-port integer register file for the yadan core. It provides NUM_RD read ports with write-to-read bypass, two writeback ports (ALU and load), a per-register busy scoreboard for hazard detection, a handshaked debug access port, and a sequential soft-clear engine. It sits between decode (reads, issue) and writeback, and serves as the drop-in successor of the single-write, two-read register file.

---
 rtl/regsfile_mp_pkg.sv | 14 +
 rtl/regsfile_rdport.sv | 45 ++++
 rtl/regsfile_mp.sv | 149 ++++++++++++++
 tb/tb_regsfile_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regsfile_mp_pkg.sv
// Shared definitions for the multi-port yadan register file:
// default widths and the controller state encoding.
package regsfile_mp_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_DBG_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/regsfile_rdport.sv
// One combinational read port: enable, x0 masking, two-write bypass
// (port 1 over port 0) and busy qualification against same-cycle writes.
module regsfile_rdport #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              busy_bit,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    logic hit0;
    logic hit1;
    logic live;

    always_comb begin
        live = re && (raddr != '0);
        hit0 = w0_en && (w0_addr == raddr);
        hit1 = w1_en && (w1_addr == raddr);
    end

    always_comb begin
        rdata = '0;
        if (live) begin
            if (hit1)      rdata = w1_data;
            else if (hit0) rdata = w0_data;
            else           rdata = arr_data;
        end
    end

    // Write enables arrive already gated for x0 and soft clear.
    always_comb begin
        busy = live && busy_bit && !(hit0 || hit1);
    end

endmodule

// File: rtl/regsfile_mp.sv
// yadan multi-port register file: NUM_RD bypassed read ports, ALU/load
// writeback, busy scoreboard, handshaked debug port and soft-clear engine.
module regsfile_mp
    import regsfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0_i,
    input  logic [ADDR_W-1:0]          waddr0_i,
    input  logic [DATA_W-1:0]          wdata0_i,
    input  logic                       we1_i,
    input  logic [ADDR_W-1:0]          waddr1_i,
    input  logic [DATA_W-1:0]          wdata1_i,
    input  logic [NUM_RD-1:0]          re_i,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
    output logic [NUM_RD*DATA_W-1:0]   rdata_o,
    output logic [NUM_RD-1:0]          busy_o,
    input  logic                       issue_i,
    input  logic [ADDR_W-1:0]          issue_addr_i,
    input  logic                       dbg_req_i,
    input  logic                       dbg_we_i,
    input  logic [ADDR_W-1:0]          dbg_addr_i,
    input  logic [DATA_W-1:0]          dbg_wdata_i,
    output logic                       dbg_ack_o,
    output logic [DATA_W-1:0]          dbg_rdata_o,
    input  logic                       clr_req_i,
    output logic                       clr_busy_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_next;

    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    busy;

    logic                core_en;
    logic                w0_en;
    logic                w1_en;
    logic                set_en;
    logic                dbg_go;

    always_comb begin
        core_en = (state != ST_CLEAR);
        w0_en   = core_en && we0_i && (waddr0_i != '0);
        w1_en   = core_en && we1_i && (waddr1_i != '0);
        set_en  = core_en && issue_i && (issue_addr_i != '0);
        dbg_go  = (state == ST_IDLE) && !clr_req_i && dbg_req_i && !we0_i && !we1_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_next = ST_CLEAR;
                    cnt_next   = ADDR_W'(1);
                end else if (dbg_go) begin
                    state_next = ST_DBG_ACK;
                end
            end
            ST_CLEAR: begin
                // cnt wraps back to 0 on the final step.
                cnt_next = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(DEPTH - 1)) state_next = ST_IDLE;
            end
            ST_DBG_ACK: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dbg_ack_o  = (state == ST_DBG_ACK);
        clr_busy_o = (state == ST_CLEAR);
    end

    // Port 1 assignment follows port 0 so it wins on a shared address;
    // the issue set follows both writes so set wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy        <= '0;
            dbg_rdata_o <= '0;
        end else begin
            if (state == ST_CLEAR) begin
                regs[cnt] <= '0;
                busy[cnt] <= 1'b0;
            end
            if (w0_en) begin
                regs[waddr0_i] <= wdata0_i;
                busy[waddr0_i] <= 1'b0;
            end
            if (w1_en) begin
                regs[waddr1_i] <= wdata1_i;
                busy[waddr1_i] <= 1'b0;
            end
            if (set_en) busy[issue_addr_i] <= 1'b1;
            if (dbg_go) begin
                if (dbg_we_i) begin
                    if (dbg_addr_i != '0) regs[dbg_addr_i] <= dbg_wdata_i;
                end else begin
                    dbg_rdata_o <= regs[dbg_addr_i];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr_i[k*ADDR_W +: ADDR_W];

        regsfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .re       (re_i[k]),
            .raddr    (ra),
            .w0_en    (w0_en),
            .w0_addr  (waddr0_i),
            .w0_data  (wdata0_i),
            .w1_en    (w1_en),
            .w1_addr  (waddr1_i),
            .w1_data  (wdata1_i),
            .arr_data (regs[ra]),
            .busy_bit (busy[ra]),
            .rdata    (rdata_o[k*DATA_W +: DATA_W]),
            .busy     (busy_o[k])
        );
    end

endmodule

// File: tb/tb_regsfile_mp.sv
// Directed self-checking bench for regsfile_mp with hand-computed expectations.
module tb_regsfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  busy;
    logic        issue;
    logic [4:0]  issue_addr;
    logic        dbg_req, dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        clr_req;
    logic        clr_busy;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    regsfile_mp #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we0_i        (we0),
        .waddr0_i     (waddr0),
        .wdata0_i     (wdata0),
        .we1_i        (we1),
        .waddr1_i     (waddr1),
        .wdata1_i     (wdata1),
        .re_i         (re),
        .raddr_i      (raddr),
        .rdata_o      (rdata),
        .busy_o       (busy),
        .issue_i      (issue),
        .issue_addr_i (issue_addr),
        .dbg_req_i    (dbg_req),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_ack_o    (dbg_ack),
        .dbg_rdata_o  (dbg_rdata),
        .clr_req_i    (clr_req),
        .clr_busy_o   (clr_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        we0 = 0; waddr0 = 0; wdata0 = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0;
        re = 2'b00; raddr = '0;
        issue = 0; issue_addr = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        clr_req = 0;
        #12;
        re = 2'b11; raddr = {5'd9, 5'd5};
        #1;
        check("rst_rdata", rdata[31:0], 32'h0);
        check("rst_busy", {30'd0, busy}, 32'h0);
        check("rst_ack", {31'd0, dbg_ack}, 32'h0);
        check("rst_dbg_rdata", dbg_rdata, 32'h0);
        check("rst_clr_busy", {31'd0, clr_busy}, 32'h0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Write x5 with same-cycle bypass
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; re = 2'b01; raddr = {5'd0, 5'd5};
        #1 check("bypass_x5", rdata[31:0], 32'hDEADBEEF);
        tick(); we0 = 0;
        #1 check("array_x5", rdata[31:0], 32'hDEADBEEF);
        tick();
        check("array_x5_later", rdata[31:0], 32'hDEADBEEF);

        // Dual write to x7: port 1 wins
        we0 = 1; waddr0 = 7; wdata0 = 32'h11; we1 = 1; waddr1 = 7; wdata1 = 32'h22;
        re = 2'b11; raddr = {5'd7, 5'd7};
        #1 check("dual_bypass_p0", rdata[31:0], 32'h22);
        check("dual_bypass_p1", rdata[63:32], 32'h22);
        tick(); we0 = 0; we1 = 0;
        #1 check("dual_stored", rdata[63:32], 32'h22);

        // x0 stays zero
        we0 = 1; waddr0 = 0; wdata0 = 32'h55; raddr = {5'd7, 5'd0};
        #1 check("x0_bypass", rdata[31:0], 32'h0);
        tick(); we0 = 0;
        #1 check("x0_array", rdata[31:0], 32'h0);

        // Scoreboard
        issue = 1; issue_addr = 3;
        tick(); issue = 0; raddr = {5'd0, 5'd3}; re = 2'b01;
        #1 check("busy_set", {31'd0, busy[0]}, 32'h1);
        re = 2'b00;
        #1 check("busy_re_low", {31'd0, busy[0]}, 32'h0);
        check("rdata_re_low", rdata[31:0], 32'h0);
        re = 2'b01; we1 = 1; waddr1 = 3; wdata1 = 32'h33;
        #1 check("busy_clr_same", {31'd0, busy[0]}, 32'h0);
        check("rdata_p1_bypass", rdata[31:0], 32'h33);
        tick(); we1 = 0;
        #1 check("busy_cleared", {31'd0, busy[0]}, 32'h0);
        issue = 1; issue_addr = 3; we0 = 1; waddr0 = 3; wdata0 = 32'h44;
        tick(); issue = 0; we0 = 0;
        #1 check("busy_set_wins", {31'd0, busy[0]}, 32'h1);
        check("x3_value", rdata[31:0], 32'h44);
        issue = 1; issue_addr = 0;
        tick(); issue = 0; raddr = {5'd0, 5'd0};
        #1 check("x0_never_busy", {31'd0, busy[0]}, 32'h0);

        // Debug read delayed by core writes
        we0 = 1; waddr0 = 9; wdata0 = 32'h1234;
        tick();
        waddr0 = 10; wdata0 = 32'hAA; dbg_req = 1; dbg_we = 0; dbg_addr = 9;
        tick();
        check("dbg_wait1", {31'd0, dbg_ack}, 32'h0);
        tick();
        check("dbg_wait2", {31'd0, dbg_ack}, 32'h0);
        we0 = 0;
        tick();
        check("dbg_ack", {31'd0, dbg_ack}, 32'h1);
        check("dbg_rdata", dbg_rdata, 32'h1234);
        dbg_req = 0;
        tick();
        check("dbg_ack_pulse", {31'd0, dbg_ack}, 32'h0);
        check("dbg_rdata_hold", dbg_rdata, 32'h1234);

        // Debug write
        dbg_req = 1; dbg_we = 1; dbg_addr = 12; dbg_wdata = 32'hCAFE;
        tick();
        check("dbgw_ack", {31'd0, dbg_ack}, 32'h1);
        dbg_req = 0; dbg_we = 0;
        tick();
        raddr = {5'd0, 5'd12};
        #1 check("dbgw_value", rdata[31:0], 32'hCAFE);
        check("dbgw_rdata_hold", dbg_rdata, 32'h1234);

        // Load everything, mark x8 busy, then soft clear
        for (int i = 1; i < 32; i++) begin
            we0 = 1; waddr0 = 5'(i); wdata0 = 32'h100 + 32'(i);
            tick();
        end
        we0 = 0; issue = 1; issue_addr = 8;
        tick(); issue = 0; raddr = {5'd8, 5'd31}; re = 2'b11;
        #1 check("loaded_x31", rdata[31:0], 32'h11F);
        check("busy_x8", {31'd0, busy[1]}, 32'h1);
        clr_req = 1;
        tick(); clr_req = 0;
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            n++;
            if (n == 10) begin
                we0 = 1; waddr0 = 4; wdata0 = 32'hBAD;
            end else begin
                we0 = 0;
            end
            tick();
        end
        we0 = 0;
        check("clr_cycles", n, 32'd31);
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(i), 5'(i)};
            #1;
            check($sformatf("clr_x%0d", i), rdata[31:0], 32'h0);
            check($sformatf("clr_busy_x%0d", i), {30'd0, busy}, 32'h0);
        end

        // Reset during CLEAR
        we0 = 1; waddr0 = 20; wdata0 = 32'h20;
        tick(); we0 = 0;
        dbg_req = 1; dbg_addr = 20;
        tick(); dbg_req = 0;
        tick();
        check("pre_rst_dbg", dbg_rdata, 32'h20);
        clr_req = 1;
        tick(); clr_req = 0;
        repeat (9) tick();
        check("clr_active", {31'd0, clr_busy}, 32'h1);
        rst = 1;
        #1;
        raddr = {5'd0, 5'd20};
        #1;
        check("rst_mid_clr_busy", {31'd0, clr_busy}, 32'h0);
        check("rst_mid_ack", {31'd0, dbg_ack}, 32'h0);
        check("rst_mid_dbg_rdata", dbg_rdata, 32'h0);
        check("rst_mid_x20", rdata[31:0], 32'h0);
        @(negedge clk) rst = 0;
        tick();
        check("post_rst_idle", {31'd0, clr_busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
